// File: rtl/ghost_motion_update.sv
`default_nettype none
// ============================================================================
// Module   : ghost_motion_update
// Purpose  : Per-ghost life cycle (home / active / respawn) and tile-grid
//            pixel motion with x tunnel wrap.
// Revision : 1.0  initial release
// ============================================================================
module ghost_motion_update #(
    parameter logic [10:0] HOME_X        = 11'd320,
    parameter logic [9:0]  HOME_Y        = 10'd224,
    parameter int          TILE          = 16,
    parameter int          STEP          = 2,
    parameter logic [10:0] X_WRAP_MAX    = 11'd624,
    parameter logic [7:0]  RELEASE_TICKS = 8'd60,
    parameter logic [7:0]  RESPAWN_TICKS = 8'd120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        freeze,
    input  logic        ghost_caught,
    input  logic [3:0]  move_direction,
    input  logic [3:0]  valid_moves,
    output logic [10:0] ghost_pos_x,
    output logic [9:0]  ghost_pos_y,
    output logic [3:0]  prev_direction,
    output logic        ghost_active
);

    localparam logic [3:0]  c_RIGHT  = 4'b0001;
    localparam logic [3:0]  c_UP     = 4'b0010;
    localparam logic [3:0]  c_DOWN   = 4'b0100;
    localparam logic [3:0]  c_LEFT   = 4'b1000;
    localparam logic [10:0] c_STEP_X = 11'(STEP);
    localparam logic [9:0]  c_STEP_Y = 10'(STEP);
    localparam logic [10:0] c_TILE_X = 11'(TILE);
    localparam logic [9:0]  c_TILE_Y = 10'(TILE);

    typedef enum logic [1:0] {
        ST_HOME    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RESPAWN = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [10:0] r_x, w_x_nxt;
    logic [9:0]  r_y, w_y_nxt;
    logic [3:0]  r_dir, w_dir_nxt;
    logic        w_aligned;
    logic [3:0]  w_dir_sel;
    logic [10:0] w_y_down;

    assign w_aligned = ((r_x % c_TILE_X) == 11'd0) && ((r_y % c_TILE_Y) == 10'd0);
    // One extra bit exposes a DOWN step that would leave the 10-bit range
    assign w_y_down  = {1'b0, r_y} + c_STEP_X;

    always_comb begin
        w_dir_sel = r_dir;
        if (w_aligned) begin
            if ($onehot(move_direction) && ((move_direction & valid_moves) != 4'd0)) begin
                w_dir_sel = move_direction;
            end else if ((r_dir & valid_moves) != 4'd0) begin
                w_dir_sel = r_dir;
            end else begin
                w_dir_sel = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HOME;
            r_cnt   <= 8'd0;
            r_x     <= HOME_X;
            r_y     <= HOME_Y;
            r_dir   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_dir_nxt   = r_dir;
        if (!freeze) begin
            if (ghost_caught) begin
                w_state_nxt = ST_RESPAWN;
                w_cnt_nxt   = 8'd0;
                w_x_nxt     = HOME_X;
                w_y_nxt     = HOME_Y;
                w_dir_nxt   = 4'd0;
            end else if (tick) begin
                case (r_state)
                    ST_HOME: begin
                        if (r_cnt == RELEASE_TICKS - 8'd1) begin
                            w_state_nxt = ST_ACTIVE;
                            w_cnt_nxt   = 8'd0;
                            w_dir_nxt   = 4'd0;
                        end else begin
                            w_cnt_nxt = r_cnt + 8'd1;
                        end
                    end
                    ST_RESPAWN: begin
                        w_x_nxt   = HOME_X;
                        w_y_nxt   = HOME_Y;
                        w_dir_nxt = 4'd0;
                        if (r_cnt == RESPAWN_TICKS - 8'd1) begin
                            w_state_nxt = ST_ACTIVE;
                            w_cnt_nxt   = 8'd0;
                        end else begin
                            w_cnt_nxt = r_cnt + 8'd1;
                        end
                    end
                    ST_ACTIVE: begin
                        w_dir_nxt = w_dir_sel;
                        // A blocked vertical edge stops the ghost instead of wrapping
                        case (w_dir_sel)
                            c_RIGHT: w_x_nxt = (r_x == X_WRAP_MAX) ? 11'd0 : r_x + c_STEP_X;
                            c_LEFT:  w_x_nxt = (r_x == 11'd0) ? X_WRAP_MAX : r_x - c_STEP_X;
                            c_DOWN: begin
                                if (w_y_down[10]) w_dir_nxt = 4'd0;
                                else              w_y_nxt   = w_y_down[9:0];
                            end
                            c_UP: begin
                                if (r_y == 10'd0) w_dir_nxt = 4'd0;
                                else              w_y_nxt   = r_y - c_STEP_Y;
                            end
                            default: w_dir_nxt = 4'd0;
                        endcase
                    end
                    default: w_state_nxt = ST_HOME;
                endcase
            end
        end
    end

    assign ghost_pos_x    = r_x;
    assign ghost_pos_y    = r_y;
    assign prev_direction = r_dir;
    assign ghost_active   = (r_state == ST_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_ghost_motion_update.sv
`default_nettype none
// ============================================================================
// Module   : tb_ghost_motion_update
// Purpose  : Directed + randomized check of ghost_motion_update against a
//            behavioural reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ghost_motion_update;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        freeze = 1'b0;
    logic        ghost_caught = 1'b0;
    logic [3:0]  move_direction = 4'd0;
    logic [3:0]  valid_moves = 4'd0;
    logic [10:0] ghost_pos_x;
    logic [9:0]  ghost_pos_y;
    logic [3:0]  prev_direction;
    logic        ghost_active;

    int n_checks = 0;
    int n_pass   = 0;

    ghost_motion_update dut (
        .clk            (clk),
        .rst            (rst),
        .tick           (tick),
        .freeze         (freeze),
        .ghost_caught   (ghost_caught),
        .move_direction (move_direction),
        .valid_moves    (valid_moves),
        .ghost_pos_x    (ghost_pos_x),
        .ghost_pos_y    (ghost_pos_y),
        .prev_direction (prev_direction),
        .ghost_active   (ghost_active)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0=home 1=active 2=respawn, m_cnt = ticks spent in phase
    int m_phase = 0, m_cnt = 0, m_x = 320, m_y = 224, m_dir = 0;
    bit m_ready = 1'b0;

    always @(posedge clk) begin
        int d, nx, ny;
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_x = 320; m_y = 224; m_dir = 0; m_ready = 1'b1;
        end else if (freeze) begin
            m_phase = m_phase;
        end else if (ghost_caught) begin
            m_phase = 2; m_cnt = 0; m_x = 320; m_y = 224; m_dir = 0;
        end else if (tick) begin
            if (m_phase == 0) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == 60) begin m_phase = 1; m_cnt = 0; m_dir = 0; end
            end else if (m_phase == 2) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == 120) begin m_phase = 1; m_cnt = 0; end
            end else begin
                if ((m_x % 16 == 0) && (m_y % 16 == 0)) begin
                    if ($countones(move_direction) == 1 && (int'(move_direction) & int'(valid_moves)) != 0)
                        d = int'(move_direction);
                    else if (m_dir != 0 && (m_dir & int'(valid_moves)) != 0)
                        d = m_dir;
                    else
                        d = 0;
                end else begin
                    d = m_dir;
                end
                nx = m_x; ny = m_y;
                if (d == 1) nx = m_x + 2;
                if (d == 8) nx = m_x - 2;
                if (d == 4) ny = m_y + 2;
                if (d == 2) ny = m_y - 2;
                if (nx < 0)   nx = 624;
                if (nx > 624) nx = 0;
                if (ny < 0 || ny > 1023) begin ny = m_y; d = 0; end
                m_x = nx; m_y = ny; m_dir = d;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic compare_model();
        if (m_ready) begin
            chk("model_x",      int'(ghost_pos_x),    m_x);
            chk("model_y",      int'(ghost_pos_y),    m_y);
            chk("model_dir",    int'(prev_direction), m_dir);
            chk("model_active", int'(ghost_active),   (m_phase == 1) ? 1 : 0);
        end
    endtask

    task automatic cyc(input logic t, input logic [3:0] mv, input logic [3:0] vm,
                       input logic c, input logic f, input logic r);
        tick = t; move_direction = mv; valid_moves = vm;
        ghost_caught = c; freeze = f; rst = r;
        @(negedge clk);
        compare_model();
    endtask

    task automatic ticks(input int n, input logic [3:0] mv, input logic [3:0] vm);
        for (int i = 0; i < n; i++) cyc(1'b1, mv, vm, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] mv;
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("reset_x", int'(ghost_pos_x), 320);
        chk("reset_y", int'(ghost_pos_y), 224);
        chk("reset_dir", int'(prev_direction), 0);
        chk("reset_active", int'(ghost_active), 0);

        ticks(59, 4'b0001, 4'b1111);
        chk("home_59_active", int'(ghost_active), 0);
        chk("home_59_x", int'(ghost_pos_x), 320);
        ticks(1, 4'b0001, 4'b1111);
        chk("release_active", int'(ghost_active), 1);
        chk("release_dir", int'(prev_direction), 0);

        ticks(1, 4'b0001, 4'b1001);
        ticks(7, 4'b0010, 4'b1001);
        chk("right_tile_x", int'(ghost_pos_x), 336);
        chk("right_tile_dir", int'(prev_direction), 1);

        ticks(1, 4'b0010, 4'b1001);
        chk("keep_prev_x", int'(ghost_pos_x), 338);
        chk("keep_prev_dir", int'(prev_direction), 1);
        ticks(7, 4'b0010, 4'b1001);
        ticks(1, 4'b0010, 4'b0000);
        chk("stop_x", int'(ghost_pos_x), 352);
        chk("stop_dir", int'(prev_direction), 0);

        ticks(176, 4'b1000, 4'b1000);
        chk("left_to_zero_x", int'(ghost_pos_x), 0);
        ticks(1, 4'b1000, 4'b1000);
        chk("wrap_left_x", int'(ghost_pos_x), 624);
        ticks(1, 4'b0001, 4'b0001);
        chk("wrap_right_x", int'(ghost_pos_x), 0);

        ticks(200, 4'b0001, 4'b0001);
        ticks(64, 4'b0010, 4'b0010);
        chk("pre_catch_x", int'(ghost_pos_x), 400);
        chk("pre_catch_y", int'(ghost_pos_y), 96);
        cyc(1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);
        chk("caught_x", int'(ghost_pos_x), 320);
        chk("caught_y", int'(ghost_pos_y), 224);
        chk("caught_active", int'(ghost_active), 0);
        ticks(60, 4'b0001, 4'b1111);
        for (int i = 0; i < 50; i++) cyc(1'b1, 4'b0001, 4'b1111, i[0], 1'b1, 1'b0);
        ticks(59, 4'b0001, 4'b1111);
        chk("respawn_119_active", int'(ghost_active), 0);
        ticks(1, 4'b0001, 4'b1111);
        chk("respawn_done_active", int'(ghost_active), 1);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1) == 0) mv = 4'(1 << $urandom_range(0, 3));
            else                           mv = 4'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 1)), mv, 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 999) == 0));
        end

        cyc(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        ticks(60, 4'b0001, 4'b0001);
        ticks(5, 4'b0001, 4'b0001);
        chk("pre_rst_x", int'(ghost_pos_x), 330);
        cyc(1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1);
        chk("midtile_rst_x", int'(ghost_pos_x), 320);
        chk("midtile_rst_dir", int'(prev_direction), 0);
        chk("midtile_rst_active", int'(ghost_active), 0);
        ticks(59, 4'b0001, 4'b0001);
        chk("rst_cnt_59_active", int'(ghost_active), 0);
        ticks(1, 4'b0001, 4'b0001);
        chk("rst_cnt_60_active", int'(ghost_active), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
